// File: rtl/alu_pkg.sv
// Shared ALU definitions: function codes, FSM states and ALUOp encodings.
// Also used by the ALU control decoder.
package alu_pkg;

  localparam logic [5:0] ALU_ADDU = 6'b001011;
  localparam logic [5:0] ALU_SUBU = 6'b001101;
  localparam logic [5:0] ALU_AND  = 6'b010010;
  localparam logic [5:0] ALU_SLL  = 6'b100110;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } alu_state_t;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } alu_op_t;

  function automatic logic is_legal(input logic [5:0] f);
    return f inside {ALU_ADDU, ALU_SUBU, ALU_AND, ALU_SLL};
  endfunction

endpackage

// File: rtl/alu_datapath.sv
// Combinational ALU datapath selected by funct.
// ALU_FAST_SHIFT_EN: sll is a full barrel shift, otherwise a single-bit step.
module alu_datapath
  import alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = '0;
    unique case (1'b1)
      (funct == ALU_ADDU): y = a + b;
      (funct == ALU_SUBU): y = a - b;
      (funct == ALU_AND):  y = a & b;
`ifdef ALU_FAST_SHIFT_EN
      (funct == ALU_SLL):  y = a << b[SHAMT_W-1:0];
`else
      (funct == ALU_SLL):  y = a << 1;
`endif
      default:             y = '0;
    endcase
  end

endmodule

// File: rtl/alu_exec.sv
// Registered execute unit with valid/ready handshake on both sides.
// ALU_FAST_SHIFT_EN: single-cycle sll; otherwise sll iterates one bit per cycle.
module alu_exec
  import alu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             illegal
);

  alu_state_t       state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             illegal_q, illegal_d;
  logic [5:0]       dp_funct;
  logic [WIDTH-1:0] dp_a;
  logic [WIDTH-1:0] dp_y;
`ifndef ALU_FAST_SHIFT_EN
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
`endif

  alu_datapath #(
    .WIDTH   (WIDTH),
    .SHAMT_W (SHAMT_W)
  ) u_dp (
    .funct (dp_funct),
    .a     (dp_a),
    .b     (src2),
    .y     (dp_y)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result_q  <= '0;
      illegal_q <= 1'b0;
`ifndef ALU_FAST_SHIFT_EN
      cnt_q     <= '0;
`endif
    end else begin
      result_q  <= result_d;
      illegal_q <= illegal_d;
`ifndef ALU_FAST_SHIFT_EN
      cnt_q     <= cnt_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    illegal_d = illegal_q;
    dp_funct  = funct;
    dp_a      = src1;
`ifndef ALU_FAST_SHIFT_EN
    cnt_d     = cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          result_d  = dp_y;
          illegal_d = !is_legal(funct);
          state_d   = DONE;
`ifndef ALU_FAST_SHIFT_EN
          // sll loads the operand and counts down the shift amount
          if (funct == ALU_SLL) begin
            result_d = src1;
            cnt_d    = src2[SHAMT_W-1:0];
            if (src2[SHAMT_W-1:0] != '0) state_d = SHIFT;
          end
`endif
        end
      end
`ifndef ALU_FAST_SHIFT_EN
      SHIFT: begin
        dp_funct = ALU_SLL;
        dp_a     = result_q;
        result_d = dp_y;
        cnt_d    = cnt_q - 1'b1;
        if (cnt_q == SHAMT_W'(1)) state_d = DONE;
      end
`endif
      DONE: begin
        if (out_ready) begin
          illegal_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    result    = result_q;
    zero      = (result_q == '0);
    illegal   = illegal_q;
  end

endmodule

// File: tb/tb_alu_exec.sv
// Scoreboard bench for alu_exec: directed vectors, monitor checks each result.
// Honours ALU_FAST_SHIFT_EN for the expected sll latencies.
module tb_alu_exec;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  funct;
  logic [31:0] src1;
  logic [31:0] src2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        illegal;

  typedef struct {
    logic [31:0] res;
    logic        z;
    logic        ill;
    int          lat;
    time         acc_t;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   busy    = 0;
  bit   seen    = 0;

  always #5 clk = ~clk;

  alu_exec dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .funct     (funct),
    .src1      (src1),
    .src2      (src2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .illegal   (illegal)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic int sll_lat(input int n);
`ifdef ALU_FAST_SHIFT_EN
    return 1;
`else
    return (n == 0) ? 1 : n + 1;
`endif
  endfunction

  // Monitor: compare every DONE cycle against the head, pop on consumption
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (busy) chk("in_ready_busy", 32'(in_ready), 32'd0);
      if (out_valid) begin
        if (q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_out_valid: got result %h with no request", result);
        end else begin
          chk("result", result, q[0].res);
          chk("zero", 32'(zero), 32'(q[0].z));
          chk("illegal", 32'(illegal), 32'(q[0].ill));
          if (!seen)
            chk("latency", 32'(($time - q[0].acc_t + 5) / 10), 32'(q[0].lat));
          seen = 1;
          if (out_ready) begin
            void'(q.pop_front());
            seen = 0;
            busy = 0;
          end
        end
      end
    end
  end

  task automatic issue(input logic [5:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] r,
                       input logic il, input int lat, input bit push);
    int k;
    exp_t e;
    k = 0;
    @(posedge clk); #1;
    while (!in_ready && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    if (!in_ready) begin
      n_tests++;
      n_fail++;
      $display("FAIL issue_timeout: in_ready %b expected 1", in_ready);
    end
    in_valid = 1'b1;
    funct = f;
    src1 = a;
    src2 = b;
    @(posedge clk);
    e.res = r;
    e.z = (r == 32'd0);
    e.ill = il;
    e.lat = lat;
    e.acc_t = $time;
    if (push) q.push_back(e);
    busy = 1;
    #1 in_valid = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (q.size() != 0 && k < 200) begin
      @(posedge clk);
      k++;
    end
    if (q.size() != 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain_timeout: %0d pending expected 0", q.size());
      q.delete();
      busy = 0;
    end
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    funct = '0;
    src1 = '0;
    src2 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_result", result, 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_illegal", 32'(illegal), 32'd0);
    rst_n = 1'b1;

    issue(6'b001011, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1, 1);
    drain();
    issue(6'b001101, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b0, 1, 1);
    drain();
    issue(6'b010010, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 1'b0, 1, 1);
    drain();
    issue(6'b001011, 32'h1234_5678, 32'h1111_1111, 32'h2345_6789, 1'b0, 1, 1);
    drain();
    issue(6'b100110, 32'd3, 32'hFFFF_FFE4, 32'h30, 1'b0, sll_lat(4), 1);
    drain();
    issue(6'b100110, 32'd3, 32'hFFFF_FFE0, 32'd3, 1'b0, sll_lat(0), 1);
    drain();
    issue(6'b100110, 32'd1, 32'd31, 32'h8000_0000, 1'b0, sll_lat(31), 1);
    drain();
    issue(6'b111111, 32'h1234_5678, 32'd9, 32'd0, 1'b1, 1, 1);
    drain();
    chk("illegal_cleared", 32'(illegal), 32'd0);
    chk("idle_in_ready", 32'(in_ready), 32'd1);

    // Back-pressure: hold DONE for 10 cycles, then consume and reissue
    out_ready = 1'b0;
    issue(6'b001101, 32'd100, 32'd1, 32'd99, 1'b0, 1, 1);
    repeat (11) @(posedge clk);
    #1;
    chk("bp_out_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_in_ready", 32'(in_ready), 32'd1);
    chk("bp_out_valid_drop", 32'(out_valid), 32'd0);
    issue(6'b010010, 32'hFFFF_0000, 32'h00FF_FF00, 32'h00FF_0000, 1'b0, 1, 1);
    drain();

`ifdef ALU_FAST_SHIFT_EN
    issue(6'b100110, 32'd3, 32'd31, 32'h8000_0000, 1'b0, 1, 1);
    drain();
`else
    // Reset mid-shift discards the operation
    issue(6'b100110, 32'd3, 32'd31, 32'h8000_0000, 1'b0, 32, 0);
    repeat (9) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1;
    busy = 0;
    chk("midrst_result", result, 32'd0);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    chk("post_rst_idle", 32'(in_ready), 32'd1);
`endif

    issue(6'b001011, 32'd2, 32'd3, 32'd5, 1'b0, 1, 1);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
